// File: rtl/hex_display_mux.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | hex_display_mux: time-multiplexed 4-digit hex display driver with anti-     |
// | ghost blanking; optional leading-zero blanking via HEX_DISPLAY_MUX_LZB_EN.  |
// | Revision: 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module hex_display_mux #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] value_i,
  input  logic [3:0]  digit_en_i,
  input  logic [3:0]  dp_i,
  output logic [3:0]  nibble_o,
  output logic [3:0]  an_n_o,
  output logic        dp_n_o,
  output logic        frame_o
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] c_blank    = CNT_W'(BLANK_CYCLES);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_dig;
  logic [15:0]      r_val;
  logic [3:0]       r_en;
  logic [3:0]       r_dp;

  state_t      w_state;
  logic        w_load;
  logic [15:0] w_val;
  logic [3:0]  w_en;
  logic [3:0]  w_dp;
  logic [3:0]  w_sup;
  logic        w_lit;

  assign w_state = (r_cnt < c_blank) ? ST_BLANK : ST_DRIVE;
  assign w_load  = (r_cnt == '0) && (r_dig == 2'd0);

  // The frame-start cycle must already show the freshly captured inputs.
  assign w_val = w_load ? value_i    : r_val;
  assign w_en  = w_load ? digit_en_i : r_en;
  assign w_dp  = w_load ? dp_i       : r_dp;

`ifdef HEX_DISPLAY_MUX_LZB_EN
  assign w_sup[3] = (w_val[15:12] == 4'h0);
  assign w_sup[2] = w_sup[3] && (w_val[11:8] == 4'h0);
  assign w_sup[1] = w_sup[2] && (w_val[7:4] == 4'h0);
  assign w_sup[0] = 1'b0;
`else
  assign w_sup = 4'b0000;
`endif

  assign w_lit = (w_state == ST_DRIVE) && w_en[r_dig] && !w_sup[r_dig];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt    <= '0;
      r_dig    <= 2'd0;
      r_val    <= 16'h0000;
      r_en     <= 4'h0;
      r_dp     <= 4'h0;
      nibble_o <= 4'h0;
      an_n_o   <= 4'b1111;
      dp_n_o   <= 1'b1;
      frame_o  <= 1'b0;
    end else begin
      if (r_cnt == c_cnt_last) begin
        r_cnt <= '0;
        r_dig <= r_dig + 2'd1;
      end else begin
        r_cnt <= r_cnt + c_cnt_one;
      end
      if (w_load) begin
        r_val <= value_i;
        r_en  <= digit_en_i;
        r_dp  <= dp_i;
      end
      nibble_o <= w_val[{r_dig, 2'b00} +: 4];
      an_n_o   <= w_lit ? ~(4'b0001 << r_dig) : 4'b1111;
      dp_n_o   <= w_lit ? ~w_dp[r_dig] : 1'b1;
      frame_o  <= w_load;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hex_display_mux.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | tb_hex_display_mux: scoreboard bench for hex_display_mux (8-cycle slots,    |
// | 2 blank cycles). Revision: 1.0 - initial release                            |
// +----------------------------------------------------------------------------+
module tb_hex_display_mux;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [15:0] value_i;
  logic [3:0]  digit_en_i;
  logic [3:0]  dp_i;
  logic [3:0]  nibble_o;
  logic [3:0]  an_n_o;
  logic        dp_n_o;
  logic        frame_o;

  typedef struct packed {
    logic [3:0] an;
    logic       dp;
    logic [3:0] nib;
    logic       frame;
    int         tag;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  int   n_checks = 0;
  int   n_fail   = 0;

`ifdef HEX_DISPLAY_MUX_LZB_EN
  localparam logic [3:0] c_lit_0050 = 4'b0011;
`else
  localparam logic [3:0] c_lit_0050 = 4'b1111;
`endif

  hex_display_mux #(
    .REFRESH_DIV (8),
    .BLANK_CYCLES(2)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .value_i   (value_i),
    .digit_en_i(digit_en_i),
    .dp_i      (dp_i),
    .nibble_o  (nibble_o),
    .an_n_o    (an_n_o),
    .dp_n_o    (dp_n_o),
    .frame_o   (frame_o)
  );

  always #5 clk = ~clk;

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_reset(input int tag);
    exp_t e;
    e.an = 4'b1111; e.dp = 1'b1; e.nib = 4'h0; e.frame = 1'b0; e.tag = tag;
    sb.push_back(e);
  endtask

  // Expands hand-chosen per-digit expectations (shown nibble, lit digits,
  // dp digits) into one entry per output cycle: 2 dark cycles then 6 driven.
  task automatic push_frame(input logic [15:0] nib, input logic [3:0] lit,
                            input logic [3:0] dpm, input int ncyc, input int id);
    exp_t e;
    for (int k = 0; k < ncyc; k++) begin
      int d;
      int c;
      d = k / 8;
      c = k % 8;
      e.frame = (k == 0);
      e.nib   = nib[d*4 +: 4];
      if (c < 2 || !lit[d]) begin
        e.an = 4'b1111;
        e.dp = 1'b1;
      end else begin
        e.an = ~(4'b0001 << d);
        e.dp = ~dpm[d];
      end
      e.tag = id * 100 + k;
      sb.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      m_e = sb.pop_front();
      n_checks++;
      if ({an_n_o, dp_n_o, nibble_o, frame_o} !== {m_e.an, m_e.dp, m_e.nib, m_e.frame}) begin
        n_fail++;
        $display("FAIL out_%0d: got an=%b dp=%b nib=%h frame=%b, want an=%b dp=%b nib=%h frame=%b",
                 m_e.tag, an_n_o, dp_n_o, nibble_o, frame_o,
                 m_e.an, m_e.dp, m_e.nib, m_e.frame);
      end
    end
  end

  initial begin
    rst_i      = 1'b1;
    value_i    = 16'h1234;
    digit_en_i = 4'hF;
    dp_i       = 4'h0;
    wait_cycles(3);

    push_reset(0);
    rst_i = 1'b0;
    push_frame(16'h1234, 4'hF, 4'h0, 32, 1);
    push_frame(16'h1234, 4'hF, 4'h0, 32, 2);
    push_frame(16'hABCD, 4'hF, 4'h0, 32, 3);
    wait_cycles(1);
    wait_cycles(32);

    // Mid-frame change during the dig=2 slot must not reach the display.
    wait_cycles(18);
    value_i = 16'hABCD;
    wait_cycles(14);

    digit_en_i = 4'b0101;
    push_frame(16'hABCD, 4'b0101, 4'h0, 32, 4);
    wait_cycles(32);

    digit_en_i = 4'hF;
    dp_i       = 4'b1000;
    push_frame(16'hABCD, 4'hF, 4'b1000, 32, 5);
    wait_cycles(32);

    value_i = 16'h0050;
    dp_i    = 4'h0;
    push_frame(16'h0050, c_lit_0050, 4'h0, 20, 6);
    push_reset(7);
    push_frame(16'h1234, 4'hF, 4'h0, 32, 8);
    wait_cycles(32);

    // Reset pulse while digit 2 is driven.
    wait_cycles(19);
    rst_i   = 1'b1;
    value_i = 16'h1234;
    wait_cycles(1);
    rst_i = 1'b0;
    wait_cycles(33);

    for (int i = 0; i < 8 && sb.size() > 0; i++) wait_cycles(1);
    if (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d pending entries, want 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hex_display_mux.md
HEX_DISPLAY_MUX -- requirements
Module: hex_display_mux

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, clock cycles per digit slot (legal range 4..2^20).
REQ-002 SHALL have parameter BLANK_CYCLES, default 1000, anti-ghost blank cycles at the start of each slot (legal range 1..REFRESH_DIV-2).
REQ-003 SHALL have port clk_i  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port value_i  input  16  four hex digits; digit n = value_i[4n+3:4n].
REQ-006 SHALL have port digit_en_i  input  4  bit n = 1 allows digit n to light.
REQ-007 SHALL have port dp_i  input  4  bit n = 1 lights the decimal point of digit n.
REQ-008 SHALL have port nibble_o  output  4  nibble of the current digit, feeding the downstream hex-to-7-segment decoder inputs d3..d0.
REQ-009 SHALL have port an_n_o  output  4  active-low anodes; bit n drives digit n.
REQ-010 SHALL have port dp_n_o  output  1  active-low decimal point.
REQ-011 SHALL have port frame_o  output  1  one-cycle pulse marking the start of a display frame.

Function
REQ-012 SHALL keep slot counter cnt (0..REFRESH_DIV-1) that increments every cycle and wraps to 0.
REQ-013 SHALL keep digit pointer dig (2 bits) that advances 0->1->2->3->0 on each cnt wrap.
REQ-014 SHALL be in state BLANK while cnt < BLANK_CYCLES, and in state DRIVE otherwise; no other states.
REQ-015 SHALL load shadow registers from value_i, digit_en_i and dp_i only in the cycle where cnt==0 and dig==0 (frame start); outputs use only the shadow copies.
REQ-016 SHALL register all outputs; each output reflects the cnt/dig/shadow state of the previous cycle (latency 1).
REQ-017 SHALL drive nibble_o = shadow nibble[dig] in both BLANK and DRIVE.
REQ-018 SHALL drive an_n_o[dig]=0 only in DRIVE when shadow digit_en[dig]=1 and the digit is not suppressed (REQ-025); all other an_n_o bits SHALL be 1.
REQ-019 SHALL drive an_n_o=4'b1111 and dp_n_o=1 throughout BLANK.
REQ-020 SHALL drive dp_n_o = ~shadow dp[dig] in DRIVE only when that digit's anode is driven; otherwise dp_n_o=1.
REQ-021 SHALL assert frame_o for exactly one cycle, one cycle after each shadow load, so it aligns with the registered outputs.
REQ-022 SHALL never drive more than one an_n_o bit low in any cycle.
REQ-023 SHALL ignore input changes between frame starts; a change becomes visible only after the next frame_o.

Reset
REQ-024 SHALL, on any clock edge with rst_i=1 (including mid-slot or mid-frame), set cnt=0, dig=0, shadows=0, an_n_o=4'b1111, dp_n_o=1, nibble_o=0, frame_o=0. The first cycle after rst_i falls SHALL be a frame start.

Configuration
REQ-025 SHALL support macro HEX_DISPLAY_MUX_LZB_EN. When the macro is defined, digit n (n=1..3) is suppressed if shadow nibbles n..3 are all zero; digit 0 is never suppressed; a suppressed digit also has its decimal point dark. When the macro is undefined, no suppression logic exists and only digit_en gates the anodes.

Verification (REFRESH_DIV=8, BLANK_CYCLES=2)
REQ-026 SHALL cover: reset, value_i=16'h1234, digit_en_i=4'hF -> per 8-cycle slot, an_n_o 1111 x2 then 1110 x6 with nibble_o=4; next slot 1101 x6 with nibble_o=3; then 1011 with 2; then 0111 with 1; frame_o pulses every 32 cycles.
REQ-027 SHALL cover: value_i changes 1234->ABCD during the dig=2 slot -> remaining slots still show 2 and 1; A,B,C,D appear after the next frame_o.
REQ-028 SHALL cover: digit_en_i=4'b0101 -> an_n_o[1] and an_n_o[3] stay 1 for the full frame; digits 0 and 2 light normally.
REQ-029 SHALL cover: dp_i=4'b1000 -> dp_n_o=0 only during the 6 DRIVE cycles of the dig=3 slot.
REQ-030 SHALL cover: value_i=16'h0050 -> with the macro, digits 3 and 2 stay dark, digit 1 shows 5 and digit 0 shows 0; without the macro, all four digits light.
REQ-031 SHALL cover: rst_i pulsed for 1 cycle during the dig=2 DRIVE state -> next cycle an_n_o=1111 and frame_o=0; the sequence restarts at dig=0 with a new shadow load.
